// File: rtl/elevator_scheduler.sv
// Elevator car controller: latches floor requests, SCAN direction choice,
// floor-to-floor travel timing and door dwell.
module elevator_scheduler #(
   parameter int NUM_FLOORS    = 4,
   parameter int FLOOR_W       = 2,
   parameter int TRAVEL_CYCLES = 8,
   parameter int DOOR_CYCLES   = 4
) (
   input  logic                  clock_i,
   input  logic                  reset_i,
   input  logic [NUM_FLOORS-1:0] req_i,
   input  logic                  door_hold_i,
   output logic [FLOOR_W-1:0]    current_floor_o,
   output logic                  motor_up_o,
   output logic                  motor_down_o,
   output logic                  door_open_o,
   output logic [NUM_FLOORS-1:0] pending_o,
   output logic [1:0]            state_o
);

   localparam int MAXC = (TRAVEL_CYCLES > DOOR_CYCLES) ?
                         TRAVEL_CYCLES : DOOR_CYCLES;
   localparam int TW   = (MAXC > 1) ? $clog2(MAXC) : 1;

   localparam logic [TW-1:0] TRAVEL_LAST = TW'(TRAVEL_CYCLES - 1);
   localparam logic [TW-1:0] DOOR_LAST   = TW'(DOOR_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_UP   = 2'd1,
      S_DOWN = 2'd2,
      S_DOOR = 2'd3
   } state_e;

   state_e                  state_q, state_d;
   logic [FLOOR_W-1:0]      floor_q, floor_d;
   logic [NUM_FLOORS-1:0]   pending_q, pending_d;
   logic [TW-1:0]           timer_q, timer_d;
   logic                    dir_q, dir_d;

   logic [NUM_FLOORS-1:0]   req_m;
   logic [NUM_FLOORS-1:0]   eff;
   logic [FLOOR_W-1:0]      nf_up, nf_dn;

   function automatic logic above_of(
      input logic [NUM_FLOORS-1:0] v,
      input logic [FLOOR_W-1:0]    f
   );
      logic r;
      r = 1'b0;
      for (int i = 0; i < NUM_FLOORS; i++)
         if (i > int'(f)) r = r | v[i];
      return r;
   endfunction

   function automatic logic below_of(
      input logic [NUM_FLOORS-1:0] v,
      input logic [FLOOR_W-1:0]    f
   );
      logic r;
      r = 1'b0;
      for (int i = 0; i < NUM_FLOORS; i++)
         if (i < int'(f)) r = r | v[i];
      return r;
   endfunction

   // Decisions see this cycle's requests too, so a press is acted on next cycle.
   always_comb begin
      state_d = state_q;
      floor_d = floor_q;
      dir_d   = dir_q;
      timer_d = timer_q;
      req_m   = req_i;
      if (state_q == S_DOOR) req_m[floor_q] = 1'b0;
      eff       = pending_q | req_m;
      pending_d = eff;
      nf_up     = floor_q + 1'b1;
      nf_dn     = floor_q - 1'b1;
      unique case (state_q)
         S_IDLE: begin
            timer_d = '0;
            if (eff[floor_q]) begin
               state_d            = S_DOOR;
               pending_d[floor_q] = 1'b0;
            end else if (dir_q && above_of(eff, floor_q)) begin
               state_d = S_UP;
            end else if (!dir_q && below_of(eff, floor_q)) begin
               state_d = S_DOWN;
            end else if (above_of(eff, floor_q)) begin
               state_d = S_UP;
               dir_d   = 1'b1;
            end else if (below_of(eff, floor_q)) begin
               state_d = S_DOWN;
               dir_d   = 1'b0;
            end
         end
         S_UP: begin
            if (timer_q == TRAVEL_LAST) begin
               timer_d = '0;
               floor_d = nf_up;
               if (eff[nf_up]) begin
                  state_d          = S_DOOR;
                  pending_d[nf_up] = 1'b0;
               end else if (!above_of(eff, nf_up)) begin
                  state_d = S_IDLE;
               end
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         S_DOWN: begin
            if (timer_q == TRAVEL_LAST) begin
               timer_d = '0;
               floor_d = nf_dn;
               if (eff[nf_dn]) begin
                  state_d          = S_DOOR;
                  pending_d[nf_dn] = 1'b0;
               end else if (!below_of(eff, nf_dn)) begin
                  state_d = S_IDLE;
               end
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         S_DOOR: begin
            if (door_hold_i || req_i[floor_q]) begin
               timer_d = '0;
            end else if (timer_q == DOOR_LAST) begin
               timer_d = '0;
               state_d = S_IDLE;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         state_q   <= S_IDLE;
         floor_q   <= '0;
         pending_q <= '0;
         timer_q   <= '0;
         dir_q     <= 1'b1;
      end else begin
         state_q   <= state_d;
         floor_q   <= floor_d;
         pending_q <= pending_d;
         timer_q   <= timer_d;
         dir_q     <= dir_d;
      end
   end

   assign current_floor_o = floor_q;
   assign pending_o       = pending_q;
   assign state_o         = state_q;
   assign motor_up_o      = (state_q == S_UP);
   assign motor_down_o    = (state_q == S_DOWN);
   assign door_open_o     = (state_q == S_DOOR);

endmodule

// File: tb/tb_elevator_scheduler.sv
// Scoreboard bench: stimulus queues expected state transitions, a negedge
// monitor pops and compares them along with per-cycle output decode checks.
module tb_elevator_scheduler;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] req;
   logic       hold;
   logic [1:0] floor_o;
   logic       mup, mdn, dopen;
   logic [3:0] pend;
   logic [1:0] st;

   elevator_scheduler dut (
      .clock_i         (clk),
      .reset_i         (rst),
      .req_i           (req),
      .door_hold_i     (hold),
      .current_floor_o (floor_o),
      .motor_up_o      (mup),
      .motor_down_o    (mdn),
      .door_open_o     (dopen),
      .pending_o       (pend),
      .state_o         (st)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0] st;
      logic [1:0] fl;
      logic [3:0] pd;
      int         dur;
   } ev_t;

   ev_t exp_q[$];
   int  total = 0;
   int  bad   = 0;
   logic [1:0] prev = 2'd0;
   int  run = 0;
   logic ab, bl;

   task automatic check(input string name, input int act, input int expv);
      total++;
      if (act != expv) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
      end
   endtask

   task automatic push(input logic [1:0] s, input logic [1:0] f,
                       input logic [3:0] p, input int d);
      ev_t e;
      e.st = s; e.fl = f; e.pd = p; e.dur = d;
      exp_q.push_back(e);
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (rst) begin
         prev = st;
         run  = 1;
      end else begin
         check("motor_up_decode", int'(mup), int'(st == 2'd1));
         check("motor_dn_decode", int'(mdn), int'(st == 2'd2));
         check("door_decode", int'(dopen), int'(st == 2'd3));
         ab = 1'b0;
         bl = 1'b0;
         for (int i = 0; i < 4; i++) begin
            if (i > int'(floor_o)) ab = ab | pend[i];
            if (i < int'(floor_o)) bl = bl | pend[i];
         end
         if (st == 2'd1) check("up_needs_above", int'(ab), 1);
         if (st == 2'd2) check("down_needs_below", int'(bl), 1);
         if (st != prev) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_transition: got state %0d expected none at %0t",
                        st, $time);
            end else begin
               ev_t e;
               e = exp_q.pop_front();
               check("ev_state", int'(st), int'(e.st));
               check("ev_floor", int'(floor_o), int'(e.fl));
               check("ev_pending", int'(pend), int'(e.pd));
               if (e.dur >= 0) check("ev_prev_duration", run, e.dur);
            end
            run = 1;
         end else begin
            run++;
         end
         prev = st;
      end
   end

   initial begin
      rst  = 1'b1;
      req  = 4'b1111;
      hold = 1'b0;
      tick;
      tick;
      check("rst_state", int'(st), 0);
      check("rst_floor", int'(floor_o), 0);
      check("rst_pending", int'(pend), 0);
      check("rst_motor_up", int'(mup), 0);
      check("rst_motor_dn", int'(mdn), 0);
      check("rst_door", int'(dopen), 0);
      rst = 1'b0;
      req = 4'b0000;
      tick;
      tick;

      // same-floor request, re-pulsed in door cycle 2
      push(2'd3, 2'd0, 4'b0000, -1);
      push(2'd0, 2'd0, 4'b0000, 6);
      req = 4'b0001;
      tick;
      req = 4'b0000;
      check("same_floor_pending", int'(pend), 0);
      tick;
      req = 4'b0001;
      check("same_floor_pending", int'(pend), 0);
      tick;
      req = 4'b0000;
      for (int i = 0; i < 8; i++) begin
         check("same_floor_pending", int'(pend), 0);
         tick;
      end

      // door_hold for 10 cycles
      push(2'd3, 2'd0, 4'b0000, -1);
      push(2'd0, 2'd0, 4'b0000, 14);
      req = 4'b0001;
      tick;
      req  = 4'b0000;
      hold = 1'b1;
      repeat (10) tick;
      hold = 1'b0;
      repeat (8) tick;

      // SCAN: heading to 3, floor 0 requested behind the car
      push(2'd1, 2'd0, 4'b1000, -1);
      push(2'd3, 2'd3, 4'b0001, 24);
      push(2'd0, 2'd3, 4'b0001, 4);
      push(2'd2, 2'd3, 4'b0001, 1);
      push(2'd3, 2'd0, 4'b0000, 24);
      push(2'd0, 2'd0, 4'b0000, 4);
      req = 4'b1000;
      tick;
      req = 4'b0000;
      tick;
      req = 4'b0001;
      tick;
      req = 4'b0000;
      repeat (60) tick;

      // single trip 0 -> 2
      push(2'd1, 2'd0, 4'b0100, -1);
      push(2'd3, 2'd2, 4'b0000, 16);
      push(2'd0, 2'd2, 4'b0000, 4);
      req = 4'b0100;
      tick;
      req = 4'b0000;
      repeat (24) tick;

      // reset while moving up with timer == 5
      push(2'd1, 2'd2, 4'b1001, -1);
      push(2'd0, 2'd0, 4'b0000, -1);
      req = 4'b1001;
      tick;
      req = 4'b0000;
      repeat (5) tick;
      rst = 1'b1;
      tick;
      rst = 1'b0;
      check("midrst_state", int'(st), 0);
      check("midrst_floor", int'(floor_o), 0);
      check("midrst_pending", int'(pend), 0);
      check("midrst_motor_up", int'(mup), 0);
      repeat (3) tick;
      check("midrst_stays_idle", int'(st), 0);

      for (int i = 0; i < 200 && exp_q.size() != 0; i++) tick;
      check("queue_drained", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
